// File: rtl/seq_defs.sv
// Shared constants for the 1011 serial pattern: state codes, state width and the pattern itself.
// Generator and detector blocks import this so they agree on encoding.
package seq_defs;

    localparam int         STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    localparam logic [STATE_W-1:0] S0_CODE = 3'd0;
    localparam logic [STATE_W-1:0] S1_CODE = 3'd1;
    localparam logic [STATE_W-1:0] S2_CODE = 3'd2;
    localparam logic [STATE_W-1:0] S3_CODE = 3'd3;
    localparam logic [STATE_W-1:0] S4_CODE = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S0 = S0_CODE,
        S1 = S1_CODE,
        S2 = S2_CODE,
        S3 = S3_CODE,
        S4 = S4_CODE
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_d, count_q;
    logic             sat_d, sat_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && count_q != MAX) begin
            count_d = count_q + 1'b1;
        end
        sat_d = (count_d == MAX);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector.sv
// Overlapping detector for the serial pattern 1,0,1,1 with a saturating match counter.
// All outputs are registered; state_o exposes the state register directly.
module seq_detector
    import seq_defs::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               din,
    input  logic               clr,
    output logic               match,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               sat
);

    state_e state_d, state_q;
    logic   match_d, match_q;

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (clr) begin
            state_d = S0;
        end else begin
            case (state_q)
                S0: if (en) state_d = din ? S1 : S0;
                S1: if (en) state_d = din ? S1 : S2;
                S2: if (en) state_d = din ? S3 : S0;
                S3: begin
                    if (en) begin
                        state_d = din ? S4 : S2;
                        match_d = din;
                    end
                end
                S4: if (en) state_d = din ? S1 : S2;
                // Unused codes recover to idle regardless of en.
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (match_d),
        .clr  (clr),
        .count(match_cnt),
        .sat  (sat)
    );

    assign match   = match_q;
    assign state_o = state_q;

endmodule
